// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants: activation map geometry, pooled sizes and counter widths.
package cnn_pkg;

    localparam int DATA_BITS = 8;
    localparam int CH        = 16;
    localparam int IN_W      = 28;
    localparam int IN_H      = 28;

    localparam int POOL_W    = IN_W / 2;
    localparam int POOL_H    = IN_H / 2;
    // Must match fc_top INPUT_NUM.
    localparam int FEAT_NUM  = POOL_W * POOL_H * CH;

    localparam int COL_W     = $clog2(IN_W);
    localparam int ROW_W     = $clog2(IN_H);
    localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic {
        ST_ACCEPT    = 1'b0,
        ST_SERIALIZE = 1'b1
    } pool_state_e;

endpackage

// File: rtl/maxpool2x2_serializer_smax_vec.sv
// Combinational per-lane signed maximum of two packed CH-lane vectors.
module smax_vec #(
    parameter int CH        = cnn_pkg::CH,
    parameter int DATA_BITS = cnn_pkg::DATA_BITS
) (
    input  logic [CH*DATA_BITS-1:0] a,
    input  logic [CH*DATA_BITS-1:0] b,
    output logic [CH*DATA_BITS-1:0] y
);

    function automatic logic signed [DATA_BITS-1:0] smax(
        input logic signed [DATA_BITS-1:0] x,
        input logic signed [DATA_BITS-1:0] z
    );
        return (x > z) ? x : z;
    endfunction

    for (genvar i = 0; i < CH; i++) begin : g_lane
        assign y[i*DATA_BITS +: DATA_BITS] = smax(a[i*DATA_BITS +: DATA_BITS],
                                                  b[i*DATA_BITS +: DATA_BITS]);
    end

endmodule

// File: rtl/maxpool2x2_serializer.sv
// Signed 2x2 stride-2 max-pool over a raster activation map, serialised one channel per beat for fc_top.
module maxpool2x2_serializer #(
    parameter int IN_W      = cnn_pkg::IN_W,
    parameter int IN_H      = cnn_pkg::IN_H,
    parameter int CH        = cnn_pkg::CH,
    parameter int DATA_BITS = cnn_pkg::DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH*DATA_BITS-1:0]     in_data,
    output logic                        feat_valid,
    output logic signed [DATA_BITS-1:0] feat_data,
    output logic                        frame_done
);

    import cnn_pkg::*;

    localparam int VEC_W    = CH * DATA_BITS;
    localparam int PW       = IN_W / 2;
    localparam int COL_BITS = $clog2(IN_W);
    localparam int ROW_BITS = $clog2(IN_H);
    localparam int CH_BITS  = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IN_W - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IN_H - 1);
    localparam logic [CH_BITS-1:0]  CH_LAST  = CH_BITS'(CH - 1);

    pool_state_e         state, state_nxt;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [CH_BITS-1:0]  ch_cnt;
    logic                frame_last;

    logic [VEC_W-1:0]    h_reg_p0;
    logic [VEC_W-1:0]    hmax_p0;
    logic [VEC_W-1:0]    lb_rd_p0;
    logic [VEC_W-1:0]    vmax_p0;
    logic [VEC_W-1:0]    shreg_p1;
    logic [VEC_W-1:0]    linebuf [PW];

    logic                accept;
    logic                pair_end;
    logic                win_end;
    logic                last_beat;

    assign in_ready  = (state == ST_ACCEPT);
    assign accept    = in_valid && in_ready;
    assign pair_end  = accept && col[0];
    assign win_end   = pair_end && row[0];
    assign last_beat = (state == ST_SERIALIZE) && (ch_cnt == CH_LAST);
    assign lb_rd_p0  = linebuf[col[COL_BITS-1:1]];

    smax_vec #(.CH(CH), .DATA_BITS(DATA_BITS)) u_hmax (
        .a (h_reg_p0),
        .b (in_data),
        .y (hmax_p0)
    );

    smax_vec #(.CH(CH), .DATA_BITS(DATA_BITS)) u_vmax (
        .a (lb_rd_p0),
        .b (hmax_p0),
        .y (vmax_p0)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCEPT:    if (win_end)   state_nxt = ST_SERIALIZE;
            ST_SERIALIZE: if (last_beat) state_nxt = ST_ACCEPT;
            default:                     state_nxt = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_ACCEPT;
            col        <= '0;
            row        <= '0;
            ch_cnt     <= '0;
            frame_last <= 1'b0;
            feat_valid <= 1'b0;
            feat_data  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            feat_valid <= (state == ST_SERIALIZE);
            frame_done <= last_beat && frame_last;
            if (state == ST_SERIALIZE) begin
                feat_data <= shreg_p1[DATA_BITS-1:0];
                ch_cnt    <= last_beat ? '0 : ch_cnt + 1'b1;
            end
            if (accept) begin
                col <= (col == COL_LAST) ? '0 : col + 1'b1;
                if (col == COL_LAST)
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end
            // Remember whether this window closes the frame so the pulse lands on its final beat.
            if (win_end)
                frame_last <= (row == ROW_LAST) && (col == COL_LAST);
        end
    end

    // Pool stage p0 -> serialiser p1; data path carries no reset, line buffer is written before it is read.
    always_ff @(posedge clk) begin
        if (accept && !col[0])
            h_reg_p0 <= in_data;
        if (pair_end && !row[0])
            linebuf[col[COL_BITS-1:1]] <= hmax_p0;
        if (win_end)
            shreg_p1 <= vmax_p0;
        else if (state == ST_SERIALIZE)
            shreg_p1 <= shreg_p1 >> DATA_BITS;
    end

endmodule

// File: tb/tb_maxpool2x2_serializer.sv
// Randomised self-checking bench for maxpool2x2_serializer against a window-level reference model.
module tb_maxpool2x2_serializer;

    localparam int DB  = cnn_pkg::DATA_BITS;
    localparam int NCH = cnn_pkg::CH;
    localparam int W   = cnn_pkg::IN_W;
    localparam int H   = cnn_pkg::IN_H;
    localparam int PW  = cnn_pkg::POOL_W;
    localparam int PH  = cnn_pkg::POOL_H;
    localparam int VW  = NCH * DB;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [VW-1:0]        in_data = '0;
    logic                 feat_valid;
    logic signed [DB-1:0] feat_data;
    logic                 frame_done;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   first_acc = -1;
    int   t_done = -1;
    int   fd_cnt = 0;
    int   beats = 0;
    int   run = 0;
    int   stall_total = 0;
    bit   mon_en = 1'b0;
    bit   stall_en = 1'b0;
    exp_t exp_q[$];
    int   frm [H][W][NCH];

    maxpool2x2_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] junk();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32 + 1; i++)
            v = {v[VW-1:0], 32'($urandom)} >> 0;
        return v;
    endfunction

    // mode 0: ch=c, 1: row+col, 2: -128 with -1 at window top-left, 3: all -128, else random int8
    task automatic build_frame(input int mode, input bit push);
        exp_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < NCH; k++)
                    case (mode)
                        0:       frm[r][c][k] = k;
                        1:       frm[r][c][k] = r + c;
                        2:       frm[r][c][k] = (r % 2 == 0 && c % 2 == 0) ? -1 : -128;
                        3:       frm[r][c][k] = -128;
                        default: frm[r][c][k] = int'($urandom_range(0, 255)) - 128;
                    endcase
        if (push) begin
            for (int pr = 0; pr < PH; pr++)
                for (int pc = 0; pc < PW; pc++)
                    for (int k = 0; k < NCH; k++) begin
                        case (mode)
                            0:       e.data = k;
                            1:       e.data = 2 * pr + 2 * pc + 2;
                            2:       e.data = -1;
                            3:       e.data = -128;
                            default: begin
                                e.data = frm[2*pr][2*pc][k];
                                if (frm[2*pr][2*pc+1][k] > e.data)   e.data = frm[2*pr][2*pc+1][k];
                                if (frm[2*pr+1][2*pc][k] > e.data)   e.data = frm[2*pr+1][2*pc][k];
                                if (frm[2*pr+1][2*pc+1][k] > e.data) e.data = frm[2*pr+1][2*pc+1][k];
                            end
                        endcase
                        e.last = (pr == PH - 1) && (pc == PW - 1) && (k == NCH - 1);
                        exp_q.push_back(e);
                    end
        end
    endtask

    task automatic send_pixel(input logic [VW-1:0] d, input bit gaps, input bit scramble);
        int guard;
        if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = junk();
            end
        end
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            in_valid = 1'b1;
            in_data  = scramble ? junk() : d;
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_eq("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        if (first_acc < 0) first_acc = cyc + 1;
    endtask

    task automatic drive_frame(input int npix, input bit gaps, input bit scramble);
        logic [VW-1:0] d;
        int n;
        n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (n < npix) begin
                    for (int k = 0; k < NCH; k++)
                        d[k*DB +: DB] = DB'(frm[r][c][k]);
                    send_pixel(d, gaps, scramble);
                    n++;
                end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_feat_valid", {31'b0, feat_valid}, 0);
        check_eq("rst_frame_done", {31'b0, frame_done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", {31'b0, in_ready}, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (feat_valid) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("feat_data", feat_data, e.data);
                    check_eq("frame_done", {31'b0, frame_done}, {31'b0, e.last});
                end
                if (frame_done) begin
                    fd_cnt++;
                    t_done = cyc;
                end
            end else begin
                check_eq("idle_frame_done", {31'b0, frame_done}, 0);
            end
        end
        if (stall_en) begin
            if (!in_ready) begin
                run++;
                stall_total++;
            end else if (run > 0) begin
                check_eq("stall_len", run, NCH);
                run = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_feat_valid", {31'b0, feat_valid}, 0);
        check_eq("reset_feat_data", feat_data, 0);
        check_eq("reset_frame_done", {31'b0, frame_done}, 0);
        check_eq("reset_in_ready", {31'b0, in_ready}, 1);

        // Constant frame, continuous in_valid: throughput and stall pattern
        mon_en = 1'b1;
        stall_en = 1'b1;
        build_frame(0, 1'b1);
        first_acc = -1;
        drive_frame(W * H, 1'b0, 1'b0);
        wait_drain();
        stall_en = 1'b0;
        check_eq("const_beats", beats, cnn_pkg::FEAT_NUM);
        check_eq("const_done_cnt", fd_cnt, 1);
        check_eq("frame_cycles", t_done - first_acc + 1, W * H + PW * PH * NCH);
        check_eq("stall_total", stall_total, PW * PH * NCH);

        // Gradient, continuous; then negative patterns with random gaps
        for (int m = 1; m <= 3; m++) begin
            beats = 0;
            fd_cnt = 0;
            build_frame(m, 1'b1);
            drive_frame(W * H, m != 1, 1'b0);
            wait_drain();
            check_eq("pattern_beats", beats, cnn_pkg::FEAT_NUM);
            check_eq("pattern_done_cnt", fd_cnt, 1);
        end

        // Aborted frames: reset mid-serialize, then mid-frame after 300 pixels
        mon_en = 1'b0;
        build_frame(4, 1'b0);
        drive_frame(2 * W, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        pulse_reset();
        build_frame(4, 1'b0);
        drive_frame(300, 1'b1, 1'b0);
        pulse_reset();
        beats = 0;
        fd_cnt = 0;
        mon_en = 1'b1;
        build_frame(0, 1'b1);
        drive_frame(W * H, 1'b0, 1'b0);
        wait_drain();
        check_eq("post_reset_beats", beats, cnn_pkg::FEAT_NUM);
        check_eq("post_reset_done_cnt", fd_cnt, 1);

        // Two back-to-back random frames with gaps and data churn while stalled
        beats = 0;
        fd_cnt = 0;
        build_frame(4, 1'b1);
        drive_frame(W * H, 1'b1, 1'b1);
        build_frame(4, 1'b1);
        drive_frame(W * H, 1'b1, 1'b1);
        wait_drain();
        check_eq("random_beats", beats, 2 * cnn_pkg::FEAT_NUM);
        check_eq("random_done_cnt", fd_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
